llm_gen: RTL and testbench

LLM_GEN -- requirements
Module: llm_gen

---
 rtl/llm_gen_if.sv | 29 ++
 rtl/llm_gen.sv | 126 ++++++++++++
 tb/tb_llm_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/llm_gen_if.sv
// Bundle of light-sample inputs and alarm/status outputs of llm_gen.
// Ports: green/yellow/red samples (master drives); a1..a3, deception_out, invalid,
//        current_state, timer, deception_count (slave drives).
interface llm_gen_if #(
  parameter int TIMER_W = 6,
  parameter int CNT_W   = 4
);
  logic               green;
  logic               yellow;
  logic               red;
  logic               a1;
  logic               a2;
  logic               a3;
  logic               deception_out;
  logic               invalid;
  logic [3:0]         current_state;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   deception_count;

  modport master (
    output green, yellow, red,
    input  a1, a2, a3, deception_out, invalid, current_state, timer, deception_count
  );

  modport slave (
    input  green, yellow, red,
    output a1, a2, a3, deception_out, invalid, current_state, timer, deception_count
  );
endinterface

// File: rtl/llm_gen.sv
// Light-sequence deception detector: escalates alarms while yellow persists or red is held,
// latches DECEIVE, counts DECEIVE entries. Moore outputs, one-cycle state latency, no backpressure.
// Ports: clock, reset (sync active-high), bus (llm_gen_if.slave).
// Optional macro LLM_GEN_STICKY_EN: DECEIVE is left only by reset, timer free-runs to saturation.
module llm_gen #(
  parameter int TIMER_W    = 6,
  parameter int T1         = 10,
  parameter int T2         = 20,
  parameter int T3         = 30,
  parameter int RED_HOLD   = 5,
  parameter int CLEAR_HOLD = 15,
  parameter int CNT_W      = 4
) (
  input logic     clock,
  input logic     reset,
  llm_gen_if.slave bus
);

  localparam int TMAX = (1 << TIMER_W) - 1;

  // Every hold must be reachable by a non-saturated timer.
  if (T1 < 1 || T1 > TMAX || T2 < 1 || T2 > TMAX || T3 < 1 || T3 > TMAX ||
      RED_HOLD < 1 || RED_HOLD > TMAX || CLEAR_HOLD < 1 || CLEAR_HOLD > TMAX) begin : g_bad_hold
    $error("llm_gen: hold parameter outside 1..2^TIMER_W-1");
  end

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_GREEN   = 4'd1,
    S_YEL1    = 4'd2,
    S_YEL2    = 4'd3,
    S_YEL3    = 4'd4,
    S_RED     = 4'd5,
    S_DECEIVE = 4'd6
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               invalid_q;
  logic               sample_ok;
  logic               timer_clr;   // stay in state but restart the timer
  logic               timer_hold;  // freeze the timer (invalid sample)

  assign sample_ok = (bus.green ^ bus.yellow ^ bus.red) & ~(bus.green & bus.yellow & bus.red);

  always_comb begin
    state_d    = state_q;
    timer_clr  = 1'b0;
    timer_hold = ~sample_ok;
    case (state_q)
      S_IDLE, S_GREEN: begin
        if (sample_ok) begin
          if (bus.green)       state_d = S_GREEN;
          else if (bus.red)    state_d = S_RED;
          else                 state_d = S_YEL1;
        end
      end
      S_YEL1, S_YEL2, S_YEL3: begin
        if (sample_ok) begin
          if (bus.green)       state_d = S_GREEN;
          else if (bus.red)    state_d = S_RED;
          else if (state_q == S_YEL1 && timer_q == TIMER_W'(T1 - 1)) state_d = S_YEL2;
          else if (state_q == S_YEL2 && timer_q == TIMER_W'(T2 - 1)) state_d = S_YEL3;
          else if (state_q == S_YEL3 && timer_q == TIMER_W'(T3 - 1)) state_d = S_DECEIVE;
        end
      end
      S_RED: begin
        if (sample_ok) begin
          if (bus.green)       state_d = S_GREEN;
          else if (bus.yellow) state_d = S_YEL1;
          else if (timer_q == TIMER_W'(RED_HOLD - 1)) state_d = S_DECEIVE;
        end
      end
      S_DECEIVE: begin
`ifdef LLM_GEN_STICKY_EN
        timer_hold = 1'b0;
`else
        if (sample_ok) begin
          if (bus.green) begin
            if (timer_q == TIMER_W'(CLEAR_HOLD - 1)) state_d = S_GREEN;
          end else begin
            timer_clr = 1'b1;
          end
        end
`endif
      end
      default: begin
        // Unused codes recover unconditionally.
        state_d    = S_IDLE;
        timer_hold = 1'b0;
      end
    endcase

    if (state_d != state_q || timer_clr) timer_d = '0;
    else if (timer_hold)                 timer_d = timer_q;
    else if (timer_q == TIMER_W'(TMAX))  timer_d = timer_q;
    else                                 timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      invalid_q <= ~sample_ok;
      if (state_d == S_DECEIVE && state_q != S_DECEIVE && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.a1              = (state_q == S_YEL1) || (state_q == S_YEL2) ||
                               (state_q == S_YEL3) || (state_q == S_DECEIVE);
  assign bus.a2              = (state_q == S_YEL2) || (state_q == S_YEL3) || (state_q == S_DECEIVE);
  assign bus.a3              = (state_q == S_YEL3) || (state_q == S_DECEIVE);
  assign bus.deception_out   = (state_q == S_DECEIVE);
  assign bus.invalid         = invalid_q;
  assign bus.current_state   = state_q;
  assign bus.timer           = timer_q;
  assign bus.deception_count = cnt_q;

endmodule

// File: tb/tb_llm_gen.sv
// Directed bench for llm_gen: reset, escalation paths, DECEIVE entry/exit, invalid samples,
// timer and counter saturation. Expected values are hand-derived constants.
module tb_llm_gen;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  llm_gen_if #(.TIMER_W(6), .CNT_W(4)) bus ();

  llm_gen dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one sample for n rising edges, return 1 time unit after the last edge.
  task automatic drive(input logic g, input logic y, input logic r, input int n);
    bus.green  = g;
    bus.yellow = y;
    bus.red    = r;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.green  = 1'b0;
    bus.yellow = 1'b0;
    bus.red    = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [3:0] alarms();
    return {bus.a1, bus.a2, bus.a3, bus.deception_out};
  endfunction

  initial begin
    // Reset state
    do_reset();
    chk("rst_state",  bus.current_state, 0);
    chk("rst_timer",  bus.timer, 0);
    chk("rst_inv",    bus.invalid, 0);
    chk("rst_cnt",    bus.deception_count, 0);
    chk("rst_alarms", alarms(), 4'b0000);

    // Green run then yellow escalation to YEL2
    drive(1, 0, 0, 45);
    chk("g45_state",  bus.current_state, 1);
    chk("g45_timer",  bus.timer, 44);
    chk("g45_alarms", alarms(), 4'b0000);
    drive(0, 1, 0, 10);
    chk("y10_state",  bus.current_state, 2);
    chk("y10_timer",  bus.timer, 9);
    chk("y10_alarms", alarms(), 4'b1000);
    drive(0, 1, 0, 11);
    chk("y21_state",  bus.current_state, 3);
    chk("y21_timer",  bus.timer, 10);
    chk("y21_alarms", alarms(), 4'b1100);
    drive(1, 0, 0, 1);
    chk("yg_state",   bus.current_state, 1);
    chk("yg_timer",   bus.timer, 0);

    // Yellow all the way to DECEIVE
    do_reset();
    drive(0, 1, 0, 10);
    chk("esc_y1_state", bus.current_state, 2);
    drive(0, 1, 0, 20);
    chk("esc_y2_state", bus.current_state, 3);
    chk("esc_y2_timer", bus.timer, 19);
    drive(0, 1, 0, 30);
    chk("esc_y3_state", bus.current_state, 4);
    chk("esc_y3_timer", bus.timer, 29);
    chk("esc_y3_alarms", alarms(), 4'b1110);
    drive(0, 1, 0, 1);
    chk("esc_dec_state",  bus.current_state, 6);
    chk("esc_dec_alarms", alarms(), 4'b1111);
    chk("esc_dec_cnt",    bus.deception_count, 1);
    drive(0, 1, 0, 3);
`ifdef LLM_GEN_STICKY_EN
    chk("dec_y_timer", bus.timer, 3);
`else
    chk("dec_y_timer", bus.timer, 0);
`endif
    chk("dec_y_state", bus.current_state, 6);

    // Reset from DECEIVE discards everything
    do_reset();
    chk("rst2_state",  bus.current_state, 0);
    chk("rst2_cnt",    bus.deception_count, 0);
    chk("rst2_alarms", alarms(), 4'b0000);

    // Red hold to DECEIVE, then green clearing
    drive(0, 0, 1, 5);
    chk("red5_state", bus.current_state, 5);
    chk("red5_timer", bus.timer, 4);
    drive(0, 0, 1, 1);
    chk("red_dec_state", bus.current_state, 6);
    chk("red_dec_cnt",   bus.deception_count, 1);
    drive(1, 0, 0, 14);
    chk("clr14_state", bus.current_state, 6);
    chk("clr14_timer", bus.timer, 14);
    drive(1, 0, 0, 1);
`ifdef LLM_GEN_STICKY_EN
    chk("clr15_state", bus.current_state, 6);
    drive(1, 0, 0, 100);
    chk("sticky_state", bus.current_state, 6);
    chk("sticky_timer", bus.timer, 63);
    do_reset();
    chk("sticky_rst_state", bus.current_state, 0);
    chk("sticky_rst_cnt",   bus.deception_count, 0);
`else
    chk("clr15_state",  bus.current_state, 1);
    chk("clr15_cnt",    bus.deception_count, 1);
    chk("clr15_alarms", alarms(), 4'b0000);
    drive(1, 0, 0, 100);
    chk("sat_state", bus.current_state, 1);
    chk("sat_timer", bus.timer, 63);
`endif

    // Invalid samples freeze state and timer in YEL2
    do_reset();
    drive(0, 1, 0, 18);
    chk("pre_inv_state", bus.current_state, 3);
    chk("pre_inv_timer", bus.timer, 7);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1);
      chk($sformatf("inv%0d_state", i), bus.current_state, 3);
      chk($sformatf("inv%0d_timer", i), bus.timer, 7);
      chk($sformatf("inv%0d_flag", i),  bus.invalid, 1);
    end
    drive(0, 1, 0, 1);
    chk("post_inv_flag",  bus.invalid, 0);
    chk("post_inv_timer", bus.timer, 8);
    drive(0, 0, 0, 1);
    chk("zero_inv_flag",  bus.invalid, 1);
    chk("zero_inv_state", bus.current_state, 3);
    drive(1, 1, 1, 1);
    chk("all_inv_flag",   bus.invalid, 1);
    drive(0, 0, 1, 1);
    chk("y2_red_state",   bus.current_state, 5);
    chk("y2_red_timer",   bus.timer, 0);
    drive(0, 1, 0, 1);
    chk("red_yel_state",  bus.current_state, 2);

`ifndef LLM_GEN_STICKY_EN
    // DECEIVE entry counter saturation
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 6);
      drive(1, 0, 0, 15);
    end
    chk("cnt_sat", bus.deception_count, 15);
    chk("cnt_sat_state", bus.current_state, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
